// File: rtl/x_conditioner.sv
// ---------------------------------------------------------------------------
// x_conditioner
//
// Turns a raw, asynchronous, possibly bouncing input into a clean synchronous
// level for a downstream FSM. The raw pin is first synchronised by two flops.
// A small FSM then commits a level change only after DEBOUNCE consecutive
// synchronised samples agree. Each committed change raises a one-cycle edge
// pulse.
//
// Parameters
//   DEBOUNCE  consecutive synchronised samples needed to commit a change
//             (legal range 2..255)
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   x_raw   in   raw asynchronous input (switch / pin)
//   x       out  debounced, registered level
//   x_rise  out  one-cycle pulse when x commits 0->1
//   x_fall  out  one-cycle pulse when x commits 1->0
//   busy    out  high while a candidate change is being qualified
//   st      out  current FSM state encoding (debug)
// ---------------------------------------------------------------------------
module x_conditioner #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x_raw,
  output logic       x,
  output logic       x_rise,
  output logic       x_fall,
  output logic       busy,
  output logic [1:0] st
);

  // The encoding is Gray-like: the stable states differ in both bits, and each
  // check state sits one bit away from the stable state it leaves.
  typedef enum logic [1:0] {
    LOW    = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b11,
    CHK_LO = 2'b10
  } state_t;

  // The qualifying sample that enters a check state already counts as 1.
  // Commit therefore happens when cnt has reached DEBOUNCE-1 and one more
  // agreeing sample arrives.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       w_x_s;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       r_x;
  logic       w_x_next;
  logic       r_rise;
  logic       w_rise_next;
  logic       r_fall;
  logic       w_fall_next;

  // Two-flop synchroniser. Nothing downstream ever looks at x_raw directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= x_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_x_s = r_sync2;

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOW;
      r_cnt   <= 8'd0;
      r_x     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_x     <= w_x_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  // Next-state logic.
  // Pulses default to 0, so each one can only last the single cycle in which
  // a commit happens. The level x holds unless a commit occurs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_x_next     = r_x;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;

    case (r_state)
      LOW: begin
        if (w_x_s) begin
          w_state_next = CHK_HI;
          w_cnt_next   = 8'd1;
        end else begin
          w_cnt_next   = 8'd0;
        end
      end

      CHK_HI: begin
        if (!w_x_s) begin
          // The run was too short. Drop the candidate silently.
          w_state_next = LOW;
          w_cnt_next   = 8'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = HIGH;
          w_cnt_next   = 8'd0;
          w_x_next     = 1'b1;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + 8'd1;
        end
      end

      HIGH: begin
        if (!w_x_s) begin
          w_state_next = CHK_LO;
          w_cnt_next   = 8'd1;
        end else begin
          w_cnt_next   = 8'd0;
        end
      end

      CHK_LO: begin
        if (w_x_s) begin
          w_state_next = HIGH;
          w_cnt_next   = 8'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = LOW;
          w_cnt_next   = 8'd0;
          w_x_next     = 1'b0;
          w_fall_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_next = LOW;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  assign x      = r_x;
  assign x_rise = r_rise;
  assign x_fall = r_fall;
  assign st     = r_state;
  assign busy   = (r_state == CHK_HI) || (r_state == CHK_LO);

endmodule
